// File: rtl/toplayici_hakem.sv
// Round-robin arbiter that shares one 32-bit adder between N requesters, with 64-bit adds in two passes.
// Optional signed-overflow output is enabled by defining TOPLAYICI_HAKEM_TASMA_EN.
module toplayici_hakem #(
  parameter int ISTEKCI_SAYISI = 4,
  parameter int KIMLIK_BIT     = $clog2(ISTEKCI_SAYISI)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [ISTEKCI_SAYISI-1:0]      istek_gecerli_i,
  input  logic [ISTEKCI_SAYISI-1:0]      istek_genis_i,
  input  logic [ISTEKCI_SAYISI*64-1:0]   istek_islec0_i,
  input  logic [ISTEKCI_SAYISI*64-1:0]   istek_islec1_i,
  input  logic [ISTEKCI_SAYISI-1:0]      istek_carry_i,
  output logic [ISTEKCI_SAYISI-1:0]      istek_hazir_o,
  output logic                           sonuc_gecerli_o,
  input  logic                           sonuc_hazir_i,
  output logic [63:0]                    sonuc_toplam_o,
  output logic                           sonuc_carry_o,
  output logic                           sonuc_tasma_o,
  output logic [KIMLIK_BIT-1:0]          sonuc_kimlik_o,
  output logic [31:0]                    top_islec0_o,
  output logic [31:0]                    top_islec1_o,
  output logic                           top_carry_o,
  input  logic [31:0]                    top_toplam_i,
  input  logic                           top_carry_i
);

  localparam logic [1:0] BOSTA = 2'd0;
  localparam logic [1:0] UST   = 2'd1;
  localparam logic [1:0] SONUC = 2'd2;

  logic [1:0]            r_durum;
  logic [KIMLIK_BIT-1:0] r_son_izin;
  logic [KIMLIK_BIT-1:0] r_kimlik;
  logic [63:0]           r_toplam;
  logic                  r_carry;
  logic [31:0]           r_ust_a;
  logic [31:0]           r_ust_b;

  logic                  w_izin_serbest;
  logic                  w_bulundu;
  logic                  w_izin;
  logic [KIMLIK_BIT-1:0] w_secilen;
  logic [63:0]           w_a_sec;
  logic [63:0]           w_b_sec;
  logic                  w_genis_sec;
  logic                  w_carry_sec;

  // Reset blocks granting in the same cycle so an in-flight result cannot be replaced.
  assign w_izin_serbest = !rst_i && ((r_durum == BOSTA) || ((r_durum == SONUC) && sonuc_hazir_i));

  always_comb begin
    int unsigned v_idx;
    w_bulundu = 1'b0;
    w_secilen = '0;
    v_idx     = 0;
    for (int i = 1; i <= ISTEKCI_SAYISI; i++) begin
      v_idx = (int'(r_son_izin) + i) % ISTEKCI_SAYISI;
      if (!w_bulundu && istek_gecerli_i[v_idx]) begin
        w_bulundu = 1'b1;
        w_secilen = KIMLIK_BIT'(v_idx);
      end
    end
  end

  assign w_izin      = w_izin_serbest && w_bulundu;
  assign w_a_sec     = istek_islec0_i[64*w_secilen +: 64];
  assign w_b_sec     = istek_islec1_i[64*w_secilen +: 64];
  assign w_genis_sec = istek_genis_i[w_secilen];
  assign w_carry_sec = istek_carry_i[w_secilen];

  always_comb begin
    istek_hazir_o = '0;
    if (w_izin) istek_hazir_o[w_secilen] = 1'b1;
  end

  // Adder inputs stay at zero whenever no pass is being performed.
  always_comb begin
    top_islec0_o = '0;
    top_islec1_o = '0;
    top_carry_o  = 1'b0;
    if (r_durum == UST) begin
      top_islec0_o = r_ust_a;
      top_islec1_o = r_ust_b;
      top_carry_o  = r_carry;
    end else if (w_izin) begin
      top_islec0_o = w_a_sec[31:0];
      top_islec1_o = w_b_sec[31:0];
      top_carry_o  = w_carry_sec;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum    <= BOSTA;
      r_son_izin <= KIMLIK_BIT'(ISTEKCI_SAYISI - 1);
      r_kimlik   <= '0;
      r_toplam   <= '0;
      r_carry    <= 1'b0;
      r_ust_a    <= '0;
      r_ust_b    <= '0;
    end else if (w_izin) begin
      r_toplam   <= {32'h0, top_toplam_i};
      r_carry    <= top_carry_i;
      r_kimlik   <= w_secilen;
      r_son_izin <= w_secilen;
      if (w_genis_sec) begin
        r_ust_a <= w_a_sec[63:32];
        r_ust_b <= w_b_sec[63:32];
        r_durum <= UST;
      end else begin
        r_durum <= SONUC;
      end
    end else if (r_durum == UST) begin
      r_toplam[63:32] <= top_toplam_i;
      r_carry         <= top_carry_i;
      r_durum         <= SONUC;
    end else if ((r_durum == SONUC) && sonuc_hazir_i) begin
      r_durum <= BOSTA;
    end
  end

  assign sonuc_gecerli_o = (r_durum == SONUC);
  assign sonuc_toplam_o  = r_toplam;
  assign sonuc_carry_o   = r_carry;
  assign sonuc_kimlik_o  = r_kimlik;

`ifdef TOPLAYICI_HAKEM_TASMA_EN
  logic r_genis;
  logic r_a_isaret;
  logic r_b_isaret;
  logic w_toplam_isaret;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_genis    <= 1'b0;
      r_a_isaret <= 1'b0;
      r_b_isaret <= 1'b0;
    end else if (w_izin) begin
      r_genis    <= w_genis_sec;
      r_a_isaret <= w_genis_sec ? w_a_sec[63] : w_a_sec[31];
      r_b_isaret <= w_genis_sec ? w_b_sec[63] : w_b_sec[31];
    end
  end

  assign w_toplam_isaret = r_genis ? r_toplam[63] : r_toplam[31];
  assign sonuc_tasma_o   = (r_a_isaret == r_b_isaret) && (w_toplam_isaret != r_a_isaret);
`else
  assign sonuc_tasma_o = 1'b0;
`endif

endmodule

// File: tb/tb_toplayici_hakem.sv
// Directed bench for toplayici_hakem with a behavioural 32-bit adder attached to the top_* ports.
module tb_toplayici_hakem;
  localparam int N = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    istek_gecerli_i;
  logic [N-1:0]    istek_genis_i;
  logic [N*64-1:0] istek_islec0_i;
  logic [N*64-1:0] istek_islec1_i;
  logic [N-1:0]    istek_carry_i;
  logic [N-1:0]    istek_hazir_o;
  logic            sonuc_gecerli_o;
  logic            sonuc_hazir_i;
  logic [63:0]     sonuc_toplam_o;
  logic            sonuc_carry_o;
  logic            sonuc_tasma_o;
  logic [1:0]      sonuc_kimlik_o;
  logic [31:0]     top_islec0_o;
  logic [31:0]     top_islec1_o;
  logic            top_carry_o;
  logic [31:0]     top_toplam_i;
  logic            top_carry_i;

  int n_kontrol = 0;
  int n_hata    = 0;

  always #5 clk_i = ~clk_i;

  assign {top_carry_i, top_toplam_i} = {1'b0, top_islec0_o} + {1'b0, top_islec1_o} + 33'(top_carry_o);

  toplayici_hakem #(.ISTEKCI_SAYISI(N)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .istek_gecerli_i(istek_gecerli_i), .istek_genis_i(istek_genis_i),
    .istek_islec0_i(istek_islec0_i), .istek_islec1_i(istek_islec1_i),
    .istek_carry_i(istek_carry_i), .istek_hazir_o(istek_hazir_o),
    .sonuc_gecerli_o(sonuc_gecerli_o), .sonuc_hazir_i(sonuc_hazir_i),
    .sonuc_toplam_o(sonuc_toplam_o), .sonuc_carry_o(sonuc_carry_o),
    .sonuc_tasma_o(sonuc_tasma_o), .sonuc_kimlik_o(sonuc_kimlik_o),
    .top_islec0_o(top_islec0_o), .top_islec1_o(top_islec1_o), .top_carry_o(top_carry_o),
    .top_toplam_i(top_toplam_i), .top_carry_i(top_carry_i)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int k, input logic genis, input logic [63:0] a,
                         input logic [63:0] b, input logic cin);
    istek_gecerli_i[k]        = 1'b1;
    istek_genis_i[k]          = genis;
    istek_islec0_i[64*k +: 64] = a;
    istek_islec1_i[64*k +: 64] = b;
    istek_carry_i[k]          = cin;
  endtask

  task automatic do_reset();
    rst_i           = 1'b1;
    istek_gecerli_i = '0;
    istek_genis_i   = '0;
    istek_islec0_i  = '0;
    istek_islec1_i  = '0;
    istek_carry_i   = '0;
    sonuc_hazir_i   = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_kontrol++;
    if ({sonuc_gecerli_o, istek_hazir_o, sonuc_toplam_o, sonuc_carry_o, sonuc_kimlik_o} !== '0) begin
      n_hata++;
      $display("FAIL reset_outputs: gecerli=%b hazir=%b toplam=%h carry=%b kimlik=%0d, required all 0",
               sonuc_gecerli_o, istek_hazir_o, sonuc_toplam_o, sonuc_carry_o, sonuc_kimlik_o);
    end
    n_kontrol++;
    if ({top_islec0_o, top_islec1_o, top_carry_o} !== '0) begin
      n_hata++;
      $display("FAIL reset_adder: a=%h b=%h c=%b, required 0", top_islec0_o, top_islec1_o, top_carry_o);
    end
  endtask

  task automatic test_dar();
    do_reset();
    set_req(0, 1'b0, 64'hFFFF_FFFF, 64'h1, 1'b0);
    #1;
    n_kontrol++;
    if (istek_hazir_o !== 4'b0001) begin
      n_hata++;
      $display("FAIL dar_grant: hazir=%b, required 0001", istek_hazir_o);
    end
    tick();
    istek_gecerli_i = '0;
    #1;
    n_kontrol++;
    if ({sonuc_gecerli_o, sonuc_toplam_o, sonuc_carry_o, sonuc_kimlik_o} !== {1'b1, 64'h0, 1'b1, 2'd0}) begin
      n_hata++;
      $display("FAIL dar_result: gecerli=%b toplam=%h carry=%b kimlik=%0d, required 1 0 1 0",
               sonuc_gecerli_o, sonuc_toplam_o, sonuc_carry_o, sonuc_kimlik_o);
    end
    tick();
    n_kontrol++;
    if (sonuc_gecerli_o !== 1'b0) begin
      n_hata++;
      $display("FAIL dar_accept: gecerli=%b, required 0", sonuc_gecerli_o);
    end
  endtask

  task automatic test_genis();
    do_reset();
    set_req(2, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0);
    #1;
    n_kontrol++;
    if (istek_hazir_o !== 4'b0100) begin
      n_hata++;
      $display("FAIL genis_grant: hazir=%b, required 0100", istek_hazir_o);
    end
    tick();
    // Scramble the operands: the high pass must use the latched halves.
    istek_gecerli_i = '0;
    istek_islec0_i  = {N*64{1'b1}};
    istek_islec1_i  = {N*64{1'b1}};
    #1;
    n_kontrol++;
    if ({top_carry_o, sonuc_gecerli_o, istek_hazir_o} !== {1'b1, 1'b0, 4'b0000}) begin
      n_hata++;
      $display("FAIL genis_ust: top_carry=%b gecerli=%b hazir=%b, required 1 0 0000",
               top_carry_o, sonuc_gecerli_o, istek_hazir_o);
    end
    tick();
    n_kontrol++;
    if ({sonuc_gecerli_o, sonuc_toplam_o, sonuc_carry_o, sonuc_kimlik_o}
        !== {1'b1, 64'h0000_0001_0000_0000, 1'b0, 2'd2}) begin
      n_hata++;
      $display("FAIL genis_result: gecerli=%b toplam=%h carry=%b kimlik=%0d, required 1 100000000 0 2",
               sonuc_gecerli_o, sonuc_toplam_o, sonuc_carry_o, sonuc_kimlik_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 1'b0, 64'(100 + k), 64'(k), 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_kontrol++;
      if (istek_hazir_o !== (4'b0001 << (i % N))) begin
        n_hata++;
        $display("FAIL rr_grant[%0d]: hazir=%b, required %b", i, istek_hazir_o, 4'b0001 << (i % N));
      end
      tick();
      n_kontrol++;
      if ({sonuc_gecerli_o, sonuc_kimlik_o, sonuc_toplam_o}
          !== {1'b1, 2'(i % N), 64'(100 + 2 * (i % N))}) begin
        n_hata++;
        $display("FAIL rr_result[%0d]: gecerli=%b kimlik=%0d toplam=%0d, required 1 %0d %0d", i,
                 sonuc_gecerli_o, sonuc_kimlik_o, sonuc_toplam_o, i % N, 100 + 2 * (i % N));
      end
    end
    istek_gecerli_i = '0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    sonuc_hazir_i = 1'b0;
    set_req(0, 1'b0, 64'd5, 64'd6, 1'b0);
    tick();
    istek_gecerli_i = '0;
    set_req(1, 1'b0, 64'd7, 64'd8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_kontrol++;
      if ({istek_hazir_o, sonuc_gecerli_o, sonuc_toplam_o, sonuc_kimlik_o}
          !== {4'b0000, 1'b1, 64'd11, 2'd0}) begin
        n_hata++;
        $display("FAIL stall[%0d]: hazir=%b gecerli=%b toplam=%0d kimlik=%0d, required 0000 1 11 0", i,
                 istek_hazir_o, sonuc_gecerli_o, sonuc_toplam_o, sonuc_kimlik_o);
      end
      tick();
    end
    sonuc_hazir_i = 1'b1;
    #1;
    n_kontrol++;
    if (istek_hazir_o !== 4'b0010) begin
      n_hata++;
      $display("FAIL stall_release: hazir=%b, required 0010", istek_hazir_o);
    end
    tick();
    istek_gecerli_i = '0;
    n_kontrol++;
    if ({sonuc_gecerli_o, sonuc_toplam_o, sonuc_kimlik_o} !== {1'b1, 64'd15, 2'd1}) begin
      n_hata++;
      $display("FAIL stall_reload: gecerli=%b toplam=%0d kimlik=%0d, required 1 15 1",
               sonuc_gecerli_o, sonuc_toplam_o, sonuc_kimlik_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    // Advance the pointer past requester 0 first.
    set_req(0, 1'b0, 64'd1, 64'd1, 1'b0);
    tick();
    istek_gecerli_i = '0;
    tick();
    set_req(1, 1'b1, 64'd1, 64'd2, 1'b0);
    tick();
    set_req(0, 1'b0, 64'd3, 64'd4, 1'b0);
    rst_i = 1'b1;
    #1;
    n_kontrol++;
    if (istek_hazir_o !== 4'b0000) begin
      n_hata++;
      $display("FAIL rst_mid_nogrant: hazir=%b, required 0000", istek_hazir_o);
    end
    tick();
    rst_i = 1'b0;
    #1;
    n_kontrol++;
    if ({sonuc_gecerli_o, istek_hazir_o} !== {1'b0, 4'b0001}) begin
      n_hata++;
      $display("FAIL rst_mid_after: gecerli=%b hazir=%b, required 0 0001", sonuc_gecerli_o, istek_hazir_o);
    end
    tick();
    istek_gecerli_i = '0;
    tick();
  endtask

  task automatic test_tasma();
    logic beklenen;
`ifdef TOPLAYICI_HAKEM_TASMA_EN
    beklenen = 1'b1;
`else
    beklenen = 1'b0;
`endif
    do_reset();
    set_req(3, 1'b0, 64'h7FFF_FFFF, 64'h1, 1'b0);
    tick();
    istek_gecerli_i = '0;
    n_kontrol++;
    if ({sonuc_toplam_o, sonuc_tasma_o} !== {64'h8000_0000, beklenen}) begin
      n_hata++;
      $display("FAIL tasma_dar: toplam=%h tasma=%b, required 80000000 %b", sonuc_toplam_o, sonuc_tasma_o,
               beklenen);
    end
    tick();
    set_req(3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    tick();
    istek_gecerli_i = '0;
    tick();
    n_kontrol++;
    if ({sonuc_toplam_o, sonuc_carry_o, sonuc_tasma_o} !== {64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0}) begin
      n_hata++;
      $display("FAIL tasma_genis_neg: toplam=%h carry=%b tasma=%b, required FFFFFFFFFFFFFFFD 1 0",
               sonuc_toplam_o, sonuc_carry_o, sonuc_tasma_o);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_dar();
    test_genis();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_tasma();
    $display("End of test - %0d assertions evaluated, %0d failures", n_kontrol, n_hata);
    $finish;
  end
endmodule
